// File: rtl/fust_s_issue_pkg.sv
// Shared types for the scalar FUST issue stage: per-FU issue FSM states,
// producer-tag encoding, the FUST row layout and the tag/writeback match helper.
package fust_s_issue_pkg;

    localparam int FUST_NFU  = 3;
    localparam int FUST_TAGW = 2;

    localparam logic [FUST_TAGW-1:0] TAG_NONE = 2'd0;
    localparam logic [FUST_TAGW-1:0] TAG_ALU  = 2'd1;
    localparam logic [FUST_TAGW-1:0] TAG_SLS  = 2'd2;
    localparam logic [FUST_TAGW-1:0] TAG_BR   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } issue_state_t;

    typedef struct packed {
        logic [5:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
    } fust_s_row_t;

    // An operand with no producer is always ready; otherwise it becomes ready
    // in the cycle its producing FU writes back.
    function automatic logic tag_hit(input logic [FUST_TAGW-1:0] tag,
                                     input logic [FUST_NFU-1:0]  wb);
        logic hit;
        case (tag)
            TAG_NONE: hit = 1'b1;
            TAG_ALU:  hit = wb[0];
            TAG_SLS:  hit = wb[1];
            TAG_BR:   hit = wb[2];
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/fust_s_issue_slot.sv
// Single-FU issue slot: captures a busy FUST row, tracks operand readiness,
// runs the valid/ready handshake and pulses the busy-clear on acceptance.
// Optional same-cycle writeback bypass under FUST_S_ISSUE_BYPASS_EN.
module fust_s_issue_slot
    import fust_s_issue_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  busy,
    input  logic [FUST_TAGW-1:0]  t1,
    input  logic [FUST_TAGW-1:0]  t2,
    input  fust_s_row_t           row,
    input  logic [FUST_NFU-1:0]   wb_valid,
    input  logic                  fu_ready,
    input  logic                  flush,
    output logic                  issue_valid,
    output fust_s_row_t           issue_op,
    output logic                  clr_busy
);

    issue_state_t          state_q, state_d;
    fust_s_row_t           op_q, op_d;
    logic [FUST_TAGW-1:0]  t1_q, t1_d, t2_q, t2_d;
    logic                  rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic                  valid_q, valid_d;
    logic                  clr_q, clr_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;

        case (state_q)
            IDLE: begin
                if (busy && !flush) begin
                    op_d    = row;
                    t1_d    = t1;
                    t2_d    = t2;
                    rdy1_d  = tag_hit(t1, wb_valid);
                    rdy2_d  = tag_hit(t2, wb_valid);
                    state_d = (rdy1_d && rdy2_d) ? ISSUE : WAIT;
                end
            end
            WAIT: begin
                rdy1_d = rdy1_q || tag_hit(t1_q, wb_valid);
                rdy2_d = rdy2_q || tag_hit(t2_q, wb_valid);
`ifdef FUST_S_ISSUE_BYPASS_EN
                // WAIT already offers the op in the wb cycle, so a ready FU
                // completes the handshake straight out of WAIT.
                if (rdy1_d && rdy2_d) begin
                    state_d = fu_ready ? DONE : ISSUE;
                end
`else
                if (rdy1_d && rdy2_d) begin
                    state_d = ISSUE;
                end
`endif
            end
            ISSUE: begin
                if (fu_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rdy1_d  = 1'b0;
                rdy2_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush beats any handshake completing in the same cycle.
        if (flush) begin
            state_d = IDLE;
            rdy1_d  = 1'b0;
            rdy2_d  = 1'b0;
        end

        valid_d = (state_d == ISSUE);
        clr_d   = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            op_q    <= '0;
            t1_q    <= TAG_NONE;
            t2_q    <= TAG_NONE;
            rdy1_q  <= 1'b0;
            rdy2_q  <= 1'b0;
            valid_q <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            valid_q <= valid_d;
            clr_q   <= clr_d;
        end
    end

`ifdef FUST_S_ISSUE_BYPASS_EN
    logic byp_ok;
    assign byp_ok      = (state_q == WAIT)
                       && (rdy1_q || tag_hit(t1_q, wb_valid))
                       && (rdy2_q || tag_hit(t2_q, wb_valid));
    assign issue_valid = valid_q || byp_ok;
`else
    assign issue_valid = valid_q;
`endif

    assign issue_op = op_q;
    assign clr_busy = clr_q;

endmodule

// File: rtl/fust_s_issue.sv
// Scalar FUST issue stage: one independent issue slot per scalar FU
// (ALU=0, SLS=1, BR=2). Optional writeback bypass: FUST_S_ISSUE_BYPASS_EN.
module fust_s_issue
    import fust_s_issue_pkg::*;
#(
    parameter int NFU  = 3,
    parameter int TAGW = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NFU-1:0]            fust_busy,
    input  logic [NFU-1:0][TAGW-1:0]  fust_t1,
    input  logic [NFU-1:0][TAGW-1:0]  fust_t2,
    input  fust_s_row_t               fust_op_alu,
    input  fust_s_row_t               fust_op_sls,
    input  fust_s_row_t               fust_op_br,
    input  logic [NFU-1:0]            wb_valid,
    input  logic [NFU-1:0]            fu_ready,
    input  logic                      flush,
    output logic [NFU-1:0]            issue_valid,
    output fust_s_row_t               issue_op_alu,
    output fust_s_row_t               issue_op_sls,
    output fust_s_row_t               issue_op_br,
    output logic [NFU-1:0]            clr_busy
);

    fust_s_row_t row_in [NFU];
    fust_s_row_t op_out [NFU];

    assign row_in[0] = fust_op_alu;
    assign row_in[1] = fust_op_sls;
    assign row_in[2] = fust_op_br;

    for (genvar i = 0; i < NFU; i++) begin : g_slot
        fust_s_issue_slot u_slot (
            .CLK         (CLK),
            .RST         (RST),
            .busy        (fust_busy[i]),
            .t1          (fust_t1[i]),
            .t2          (fust_t2[i]),
            .row         (row_in[i]),
            .wb_valid    (wb_valid),
            .fu_ready    (fu_ready[i]),
            .flush       (flush),
            .issue_valid (issue_valid[i]),
            .issue_op    (op_out[i]),
            .clr_busy    (clr_busy[i])
        );
    end

    assign issue_op_alu = op_out[0];
    assign issue_op_sls = op_out[1];
    assign issue_op_br  = op_out[2];

endmodule

// File: tb/tb_fust_s_issue.sv
// Self-checking bench for fust_s_issue: directed scenarios plus randomized
// traffic against a transaction-level model of each FU's issue job.
module tb_fust_s_issue;
    import fust_s_issue_pkg::*;

`ifdef FUST_S_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic [2:0]       fust_busy;
    logic [2:0][1:0]  fust_t1;
    logic [2:0][1:0]  fust_t2;
    fust_s_row_t      fust_op_alu, fust_op_sls, fust_op_br;
    logic [2:0]       wb_valid;
    logic [2:0]       fu_ready;
    logic             flush;
    logic [2:0]       issue_valid;
    fust_s_row_t      issue_op_alu, issue_op_sls, issue_op_br;
    logic [2:0]       clr_busy;

    always #5 CLK = ~CLK;

    fust_s_issue dut (
        .CLK          (CLK),
        .RST          (RST),
        .fust_busy    (fust_busy),
        .fust_t1      (fust_t1),
        .fust_t2      (fust_t2),
        .fust_op_alu  (fust_op_alu),
        .fust_op_sls  (fust_op_sls),
        .fust_op_br   (fust_op_br),
        .wb_valid     (wb_valid),
        .fu_ready     (fu_ready),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_op_alu (issue_op_alu),
        .issue_op_sls (issue_op_sls),
        .issue_op_br  (issue_op_br),
        .clr_busy     (clr_busy)
    );

    fust_s_row_t dut_op [3];
    assign dut_op[0] = issue_op_alu;
    assign dut_op[1] = issue_op_sls;
    assign dut_op[2] = issue_op_br;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FUST table as the bench sees it
    bit          tb_busy [3];
    fust_s_row_t tb_row  [3];
    logic [1:0]  tb_t1   [3];
    logic [1:0]  tb_t2   [3];

    // Per-FU job model: a job is either waiting on operands, being offered,
    // or just accepted (busy-clear this cycle).
    bit          m_wait  [3];
    bit          m_offer [3];
    bit          m_clr   [3];
    bit          m_need1 [3];
    bit          m_need2 [3];
    logic [1:0]  m_t1    [3];
    logic [1:0]  m_t2    [3];
    fust_s_row_t m_op    [3];

    function automatic bit produced(input logic [1:0] tag, input logic [2:0] wb);
        if (tag == 2'd0) return 1'b1;
        return wb[int'(tag) - 1];
    endfunction

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            tb_busy[i] = 1'b0; tb_row[i] = '0; tb_t1[i] = 2'd0; tb_t2[i] = 2'd0;
            m_wait[i] = 1'b0; m_offer[i] = 1'b0; m_clr[i] = 1'b0;
            m_need1[i] = 1'b0; m_need2[i] = 1'b0;
            m_t1[i] = 2'd0; m_t2[i] = 2'd0; m_op[i] = '0;
        end
    endtask

    task automatic drive_tbl();
        for (int i = 0; i < 3; i++) begin
            fust_busy[i] = tb_busy[i];
            fust_t1[i]   = tb_t1[i];
            fust_t2[i]   = tb_t2[i];
        end
        fust_op_alu = tb_row[0];
        fust_op_sls = tb_row[1];
        fust_op_br  = tb_row[2];
    endtask

    task automatic load(input int i, input logic [1:0] a, input logic [1:0] b);
        tb_busy[i] = 1'b1;
        tb_t1[i]   = a;
        tb_t2[i]   = b;
        tb_row[i]  = fust_s_row_t'({$urandom(), $urandom()});
    endtask

    // One clock: apply inputs, check outputs mid-cycle, advance model and table.
    task automatic step(input logic [2:0] wb, input logic [2:0] rdy, input logic fl);
        bit m1, m2, ev, clr_now;
        wb_valid = wb;
        fu_ready = rdy;
        flush    = fl;
        drive_tbl();
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            m1 = !m_need1[i] || produced(m_t1[i], wb);
            m2 = !m_need2[i] || produced(m_t2[i], wb);
            ev = m_offer[i] || (BYP && m_wait[i] && m1 && m2);
            chk($sformatf("issue_valid[%0d]", i), 64'(issue_valid[i]), 64'(ev));
            chk($sformatf("clr_busy[%0d]", i), 64'(clr_busy[i]), 64'(m_clr[i]));
            chk($sformatf("issue_op[%0d]", i), 64'(dut_op[i]), 64'(m_op[i]));
        end
        for (int i = 0; i < 3; i++) begin
            m1 = !m_need1[i] || produced(m_t1[i], wb);
            m2 = !m_need2[i] || produced(m_t2[i], wb);
            clr_now = m_clr[i];
            if (fl) begin
                m_wait[i] = 1'b0; m_offer[i] = 1'b0; m_clr[i] = 1'b0;
            end else if (m_clr[i]) begin
                m_clr[i] = 1'b0;
            end else if (m_offer[i]) begin
                if (rdy[i]) begin m_offer[i] = 1'b0; m_clr[i] = 1'b1; end
            end else if (m_wait[i]) begin
                m_need1[i] = !m1;
                m_need2[i] = !m2;
                if (m1 && m2) begin
                    m_wait[i] = 1'b0;
                    if (BYP && rdy[i]) m_clr[i] = 1'b1;
                    else m_offer[i] = 1'b1;
                end
            end else if (tb_busy[i]) begin
                m_op[i]    = tb_row[i];
                m_t1[i]    = tb_t1[i];
                m_t2[i]    = tb_t2[i];
                m_need1[i] = !produced(tb_t1[i], wb);
                m_need2[i] = !produced(tb_t2[i], wb);
                if (!m_need1[i] && !m_need2[i]) m_offer[i] = 1'b1;
                else m_wait[i] = 1'b1;
            end
            if (fl || clr_now) tb_busy[i] = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(3'b000, 3'b000, 1'b0);
    endtask

    initial begin
        RST = 1'b0;
        wb_valid = '0; fu_ready = '0; flush = 1'b0;
        mreset();
        drive_tbl();
        #1 RST = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        chk("reset issue_valid", 64'(issue_valid), 64'(0));
        chk("reset clr_busy", 64'(clr_busy), 64'(0));
        chk("reset issue_op_alu", 64'(issue_op_alu), 64'(0));
        chk("reset issue_op_br", 64'(issue_op_br), 64'(0));
        RST = 1'b0;
        idle(2);

        // No dependence on ALU
        load(0, 2'd0, 2'd0);
        step(3'b000, 3'b001, 1'b0);
        chk("nodep valid", 64'(issue_valid[0]), 64'(1));
        step(3'b000, 3'b001, 1'b0);
        chk("nodep clr", 64'(clr_busy[0]), 64'(1));
        step(3'b000, 3'b000, 1'b0);
        chk("nodep clr once", 64'(clr_busy[0]), 64'(0));
        idle(2);

        // SLS operand 1 waits on ALU writeback
        load(1, 2'd1, 2'd0);
        idle(4);
        step(3'b001, 3'b000, 1'b0);
        chk("dep valid after wb", 64'(issue_valid[1]), 64'(1));
        step(3'b000, 3'b010, 1'b0);
        idle(3);

        // Own-FU tag, wb in the capture cycle counts
        load(2, 2'd3, 2'd2);
        step(3'b100, 3'b000, 1'b0);
        idle(2);
        step(3'b010, 3'b000, 1'b0);
        step(3'b000, 3'b100, 1'b0);
        idle(3);

        // BR backpressure
        load(2, 2'd0, 2'd0);
        step(3'b000, 3'b000, 1'b0);
        for (int k = 0; k < 4; k++) step(3'b111, 3'b000, 1'b0);
        step(3'b000, 3'b100, 1'b0);
        idle(3);

        // Flush racing a handshake
        load(0, 2'd0, 2'd0);
        step(3'b000, 3'b000, 1'b0);
        step(3'b000, 3'b001, 1'b1);
        chk("flush valid", 64'(issue_valid[0]), 64'(0));
        chk("flush clr", 64'(clr_busy[0]), 64'(0));
        idle(3);

        // All three in parallel
        load(0, 2'd0, 2'd0); load(1, 2'd0, 2'd0); load(2, 2'd0, 2'd0);
        step(3'b000, 3'b000, 1'b0);
        chk("parallel valid", 64'(issue_valid), 64'(3'b111));
        step(3'b000, 3'b111, 1'b0);
        chk("parallel clr", 64'(clr_busy), 64'(3'b111));
        idle(3);

        // Async reset while offering
        load(0, 2'd0, 2'd0);
        step(3'b000, 3'b000, 1'b0);
        #2 RST = 1'b1;
        #1 chk("async rst valid", 64'(issue_valid[0]), 64'(0));
        chk("async rst clr", 64'(clr_busy), 64'(0));
        mreset();
        drive_tbl();
        @(posedge CLK); #1;
        RST = 1'b0;
        idle(3);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!tb_busy[i] && ($urandom_range(0, 2) == 0))
                    load(i, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end
            step(3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
